// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI memory subsystem: FSM states,
// RAM command codes and frame geometry.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/spi_ram.sv
// Synchronous single-port RAM driven by 10-bit command frames from the SPI slave.
// The top two frame bits select the operation, the low byte is address or data.
module spi_ram
    import spi_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_SIZE+1:0] din,
    input  logic                 rx_valid,
    output logic [ADDR_SIZE-1:0] dout,
    output logic                 tx_valid,
    output logic                 rd_addr_done
);

    logic [ADDR_SIZE-1:0] mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wrAddr_q;
    logic [ADDR_SIZE-1:0] rdAddr_q;
    logic [ADDR_SIZE-1:0] dout_q;
    logic                 txValid_q;
    logic                 rdAddrDone_q;
    logic [1:0]           cmd;

    assign cmd = din[ADDR_SIZE+1 -: 2];

    // Storage has no reset so contents survive a mid-frame reset.
    always_ff @(posedge clk) begin
        if (rx_valid && cmd == CMD_WR_DATA) begin
            mem[wrAddr_q] <= din[ADDR_SIZE-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wrAddr_q     <= '0;
            rdAddr_q     <= '0;
            dout_q       <= '0;
            txValid_q    <= 1'b0;
            rdAddrDone_q <= 1'b0;
        end else if (rx_valid) begin
            case (cmd)
                CMD_WR_ADDR: begin
                    wrAddr_q  <= din[ADDR_SIZE-1:0];
                    txValid_q <= 1'b0;
                end
                CMD_WR_DATA: begin
                    txValid_q <= 1'b0;
                end
                CMD_RD_ADDR: begin
                    rdAddr_q     <= din[ADDR_SIZE-1:0];
                    rdAddrDone_q <= 1'b1;
                    txValid_q    <= 1'b0;
                end
                default: begin
                    dout_q       <= mem[rdAddr_q];
                    txValid_q    <= 1'b1;
                    rdAddrDone_q <= 1'b0;
                end
            endcase
        end
    end

    assign dout         = dout_q;
    assign tx_valid     = txValid_q;
    assign rd_addr_done = rdAddrDone_q;

endmodule

// File: rtl/spi_wrapper.sv
// Mode-0 SPI slave (one system clock per bit) wrapped around spi_ram.
// Holds the frame FSM, the receive shifter and the MISO serializer.
module spi_wrapper
    import spi_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic MOSI,
    output logic MISO,
    input  logic SS_n
);

    // bitCnt keeps counting past the frame so it also times the read-back bits.
    localparam logic [4:0] LAST_RX  = 5'(FRAME_BITS - 1);
    localparam logic [4:0] TX_FIRST = 5'(FRAME_BITS + 1);
    localparam logic [4:0] TX_LAST  = 5'(FRAME_BITS + DATA_BITS);
    localparam logic [4:0] TX_DONE  = 5'(FRAME_BITS + DATA_BITS + 1);

    state_e                state_q;
    logic [4:0]            bitCnt_q;
    logic [FRAME_BITS-1:0] rx_q;
    logic                  rxValid_q;
    logic                  miso_q;

    logic [ADDR_SIZE-1:0]  dout;
    logic                  txValid;
    logic                  rdAddrDone;
    logic                  rxActive;
    logic                  txWindow;
    logic [2:0]            txIdx;

    assign rxActive = (bitCnt_q <= LAST_RX);
    assign txWindow = (bitCnt_q >= TX_FIRST) && (bitCnt_q <= TX_LAST);
    assign txIdx    = 3'(TX_LAST - bitCnt_q);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= IDLE;
            bitCnt_q  <= '0;
            rx_q      <= '0;
            rxValid_q <= 1'b0;
            miso_q    <= 1'b0;
        end else begin
            rxValid_q <= 1'b0;
            if (state_q != IDLE && SS_n) begin
                state_q  <= IDLE;
                bitCnt_q <= '0;
                rx_q     <= '0;
                miso_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        miso_q <= 1'b0;
                        if (!SS_n) state_q <= CHK_CMD;
                    end
                    CHK_CMD: begin
                        bitCnt_q <= '0;
                        if (!MOSI)           state_q <= WRITE;
                        else if (rdAddrDone) state_q <= READ_DATA;
                        else                 state_q <= READ_ADD;
                    end
                    WRITE, READ_ADD: begin
                        if (rxActive) begin
                            rx_q      <= {rx_q[FRAME_BITS-2:0], MOSI};
                            bitCnt_q  <= bitCnt_q + 5'd1;
                            rxValid_q <= (bitCnt_q == LAST_RX);
                        end
                    end
                    READ_DATA: begin
                        if (rxActive) begin
                            rx_q      <= {rx_q[FRAME_BITS-2:0], MOSI};
                            bitCnt_q  <= bitCnt_q + 5'd1;
                            rxValid_q <= (bitCnt_q == LAST_RX);
                        end else if (bitCnt_q != TX_DONE) begin
                            bitCnt_q <= bitCnt_q + 5'd1;
                        end
                        miso_q <= (txWindow && txValid) ? dout[txIdx] : 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign MISO = miso_q;

    spi_ram #(
        .MEM_DEPTH(MEM_DEPTH),
        .ADDR_SIZE(ADDR_SIZE)
    ) u_ram (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (rx_q),
        .rx_valid    (rxValid_q),
        .dout        (dout),
        .tx_valid    (txValid),
        .rd_addr_done(rdAddrDone)
    );

endmodule

// File: tb/tb_spi_wrapper.sv
// Self-checking bench for spi_wrapper: directed plan plus randomized
// write/read sequences checked against a frame-level memory model.
module tb_spi_wrapper;

    logic clk;
    logic rst_n;
    logic MOSI;
    logic MISO;
    logic SS_n;

    int vectors     = 0;
    int miscompares = 0;
    int rxCount     = 0;

    logic [7:0] mdlMem [256];
    logic [7:0] mdlWrAddr;
    logic [7:0] mdlRdAddr;
    bit         mdlDone;
    logic [7:0] writtenQ [$];

    spi_wrapper #(
        .MEM_DEPTH(256),
        .ADDR_SIZE(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .MOSI (MOSI),
        .MISO (MISO),
        .SS_n (SS_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts every clock edge at which the RAM sees a command strobe.
    always @(posedge clk) begin
        if (dut.u_ram.rx_valid === 1'b1) rxCount++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed still running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mdlWrAddr = 8'h00;
        mdlRdAddr = 8'h00;
        mdlDone   = 1'b0;
    endtask

    // Drives one complete frame and checks MISO and the strobe count against the model.
    task automatic doFrame(input logic cmdBit, input logic [9:0] frame);
        int         rxBefore;
        bit         expSer;
        logic [7:0] expByte;
        logic [7:0] got;
        logic [7:0] data;
        rxBefore = rxCount;
        expSer   = cmdBit && mdlDone && (frame[9:8] == 2'b11);
        expByte  = mdlMem[mdlRdAddr];
        data     = frame[7:0];
        case (frame[9:8])
            2'b00: mdlWrAddr = data;
            2'b01: begin
                mdlMem[mdlWrAddr] = data;
                writtenQ.push_back(mdlWrAddr);
            end
            2'b10: begin
                mdlRdAddr = data;
                mdlDone   = 1'b1;
            end
            default: mdlDone = 1'b0;
        endcase

        SS_n = 1'b0;
        MOSI = 1'b0;
        @(negedge clk);
        checkVal("miso_frame_start", MISO, 1'b0);
        MOSI = cmdBit;
        @(negedge clk);
        for (int i = 9; i >= 0; i--) begin
            MOSI = frame[i];
            @(negedge clk);
            checkVal("miso_during_rx", MISO, 1'b0);
        end
        if (expSer) begin
            got = 8'h00;
            for (int j = 1; j <= 10; j++) begin
                @(negedge clk);
                if (j >= 2 && j <= 9) begin
                    got[9-j] = MISO;
                    checkVal("miso_bit", MISO, expByte[9-j]);
                end else begin
                    checkVal("miso_idle_edge", MISO, 1'b0);
                end
            end
            checkVal("read_byte", got, expByte);
        end
        SS_n = 1'b1;
        @(negedge clk);
        checkVal("rx_valid_pulses", rxCount - rxBefore, 1);
        checkVal("miso_after_frame", MISO, 1'b0);
    endtask

    // Drives a truncated frame; nothing may reach the RAM.
    task automatic abortFrame(input logic cmdBit, input logic [9:0] frame, input int nBits);
        int rxBefore;
        rxBefore = rxCount;
        SS_n = 1'b0;
        MOSI = 1'b0;
        @(negedge clk);
        MOSI = cmdBit;
        @(negedge clk);
        for (int i = 9; i > 9 - nBits; i--) begin
            MOSI = frame[i];
            @(negedge clk);
        end
        SS_n = 1'b1;
        @(negedge clk);
        checkVal("abort_no_rx_valid", rxCount - rxBefore, 0);
        checkVal("abort_miso", MISO, 1'b0);
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] r;
        rst_n = 1'b1;
        SS_n  = 1'b1;
        MOSI  = 1'b0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkVal("reset_miso", MISO, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        checkVal("post_reset_miso", MISO, 1'b0);

        // Directed plan: write 0x55 to 0xFF and read it back.
        doFrame(1'b0, {2'b00, 8'hFF});
        doFrame(1'b0, {2'b01, 8'h55});
        doFrame(1'b1, {2'b10, 8'hFF});
        doFrame(1'b1, {2'b11, 8'h3B});

        // A partial write frame must not disturb memory nor the pending read address.
        doFrame(1'b1, {2'b10, 8'hFF});
        abortFrame(1'b0, {2'b01, 8'hAA}, 5);
        doFrame(1'b1, {2'b11, 8'h00});

        for (int it = 0; it < 24; it++) begin
            a = 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            doFrame(1'b0, {2'b00, a});
            doFrame(1'b0, {2'b01, d});
            r = writtenQ[$urandom_range(0, writtenQ.size() - 1)];
            doFrame(1'b1, {2'b10, r});
            doFrame(1'b1, {2'b11, 8'($urandom_range(0, 255))});
        end

        // Reset in the middle of serializing 0xFF must force MISO low at once.
        doFrame(1'b0, {2'b00, 8'h3C});
        doFrame(1'b0, {2'b01, 8'hFF});
        doFrame(1'b1, {2'b10, 8'h3C});
        SS_n = 1'b0;
        MOSI = 1'b0;
        @(negedge clk);
        MOSI = 1'b1;
        @(negedge clk);
        for (int i = 9; i >= 0; i--) begin
            MOSI = (i >= 8) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        @(negedge clk);
        @(negedge clk);
        checkVal("pre_reset_miso_bit7", MISO, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkVal("async_reset_miso", MISO, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        SS_n  = 1'b1;
        modelReset();
        @(negedge clk);
        checkVal("after_reset_miso", MISO, 1'b0);

        // Memory survives reset; write address restarts at 0.
        doFrame(1'b1, {2'b10, 8'h3C});
        doFrame(1'b1, {2'b11, 8'h00});
        doFrame(1'b0, {2'b01, 8'hA7});
        doFrame(1'b1, {2'b10, 8'h00});
        doFrame(1'b1, {2'b11, 8'h00});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
